axi_lite_cfg_reg_center: RTL and testbench
==========================================

# axi_lite_cfg_reg_center

AXI4-Lite slave that acts as the configure centre for a bank of `common_configure_reg_interface` register slices. It drives `wdata` into each slice through the `master` modport, collects `rdata`, `addr` and `default_value` from each slice, and aggregates slice interrupts into one level IRQ. It sits between the CPU-side AXI-Lite bus and the per-module `CFG_REG` family of slices.

## Interface
- `NUM`, 16: number of attached slices, 1..32.
- `ASIZE`, 8: slice address width, matches `cfg_inf.ASIZE`.
- `DSIZE`, 32: data width, fixed at 32 to match the AXI-Lite data width.
- `INTR_PEND_ADDR`, 8'hFE: reserved register address for the interrupt-pending register (W1C).
- `INTR_MASK_ADDR`, 8'hFF: reserved register address for the interrupt-mask register (RW).

Ports:
- `clock` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `awaddr` in ASIZE+2: write byte address.
- `awvalid` in 1 / `awready` out 1.
- `wdata` in 32.
- `wvalid` in 1 / `wready` out 1.
- `bresp` out 2: always 2'b00.
- `bvalid` out 1 / `bready` in 1.
- `araddr` in ASIZE+2.
- `arvalid` in 1 / `arready` out 1.
- `rdata` out 32.
- `rresp` out 2: always 2'b00.
- `rvalid` out 1 / `rready` in 1.
- `cfg_inf[NUM]` iface: `common_configure_reg_interface.master` array.
- `irq` out 1: registered, `|(pending & mask)`.

## Operation
- Register address is byte address `[ASIZE+1:2]`. Byte strobes are not supported; every write is a full-word write.
- Slot `i` holds `wreg[i]`, which drives `cfg_inf[i].wdata`.
- Slot update priority per cycle:
  1. `cfg_inf[i].rst==1`: load `default_value`.
  2. Else, committed write whose address equals `cfg_inf[i].addr`: load the AXI wdata.
  3. Else: hold.
- Self-clearing pulse registers (slice ties `rst` to its `data[0]`) therefore stay high for exactly 1 cycle.
- Duplicate slice addresses: all matching slots are written. Reads return the lowest matching index.
- Reserved addresses override slice addresses.
- Read of an unmatched address returns 0 with OKAY. Write to an unmatched address is dropped with OKAY.
- Interrupts:
  - `pending[i]` sets on a rising edge of `cfg_inf[i].interrupt_trigger` while `interrupt_enable==1`. The edge is detected against a registered copy of the trigger.
  - Writing 1 to `INTR_PEND_ADDR` bit `i` clears `pending[i]`.
  - A set in the same cycle as a clear wins (the bit stays 1).
  - Bits at index NUM and above read 0.
- Init sequence:
  - While `rst_n` is low: `wreg` = 0, `pending` = 0, `mask` = 0, `trig_d` = 0.
  - The first cycle after `rst_n` deasserts is state INIT: every slot loads `default_value`, and all readies are low.
  - The block then enters RUN.
- Write FSM:
  - W_IDLE: `awready` = `wready` = 1. Latch whichever of AW/W arrives. Both in the same cycle goes to W_COMMIT. Only one goes to W_WAIT.
  - W_WAIT: deassert the ready of the channel already latched. Go to W_COMMIT when the other arrives.
  - W_COMMIT: 1 cycle, slot update. Go to W_RESP.
  - W_RESP: `bvalid` = 1 until `bready`. Then go to W_IDLE.
- Read FSM:
  - R_IDLE: `arready` = 1. On handshake, mux `rdata` from slots/reserved registers into an output register and go to R_RESP.
  - R_RESP: `rvalid` held until `rready`. Then go to R_IDLE.
- Read and write FSMs run independently.

## Timing
- Reset values: all readies 0, `bvalid` = 0, `rvalid` = 0, `rdata` = 0, `bresp` = `rresp` = 0, `irq` = 0.
- Write latency: AW+W handshake in cycle N gives slot update at the end of N+1 (W_COMMIT). `cfg_inf.wdata` shows the new value in N+2. `bvalid` rises in N+2.
- Read latency: AR handshake in cycle N gives `rvalid` in N+1.
- Read of slot `i` in the same cycle as W_COMMIT to slot `i` returns the old value.
- A slice `rst` asserted during W_COMMIT to the same slot: `default_value` wins, `bresp` is still OKAY.
- `irq` lags the pending or mask change by 1 cycle.
- `rst_n` asserted mid-transaction: FSMs return to idle, the in-flight write is lost, and no B or R response is issued.

## Structure
- Package `cfg_center_pkg`:
  - enum `wr_state_t` {W_IDLE, W_WAIT, W_COMMIT, W_RESP}.
  - enum `rd_state_t` {R_IDLE, R_RESP}.
  - `RESP_OKAY` constant.
  - Default values for the reserved addresses.
- Sub-module `cfg_center_slot`: one per slice, instantiated under generate. Contains:
  - the `wreg` with its priority update;
  - the address match;
  - trigger edge detection and the pending bit.
- The top holds the AXI FSMs, the read mux, the mask register and `irq`.

## Test plan
- **Reset and init:** slice 3 with `default_value` = 32'h1234 and `addr` = 8'h03, release `rst_n`. Required: `cfg_inf[3].wdata` == 32'h1234 two cycles after release, and `awready` is low during INIT.
- **Split write:** AW `addr` 0x0C, then W 32'hA5A5_0001 three cycles later. Required: `awready` drops after AW, slot 3 = 32'hA5A5_0001, one B response with OKAY; a read of 0x0C returns the same value.
- **Pulse register:** slice 5 ties `rst` = `wdata[0]`, write 1. Required: `cfg_inf[5].wdata[0]` high exactly 1 cycle, then 0.
- **Interrupt:** enable slice 2, unmask bit 2, pulse its trigger. Required: `pending` = 0x4 and `irq` = 1. Write 0x4 to 0xFE (byte address 0x3F8): `irq` falls the following cycle. Trigger edge in the same cycle as the clear: `pending` stays set.
- **Unmatched address and back-pressure:** read address 0x40 with `rready` held low for 5 cycles. Required: `rvalid` stays high with `rdata` = 0 and OKAY; `arready` stays 0 until the handshake completes.

Source files
------------

// File: rtl/cfg_center_pkg.sv
// Shared types and constants for the AXI-Lite configure centre and its register slots.
package cfg_center_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;

    // Values the reserved interrupt registers take while rst_n is low.
    localparam logic [31:0] INTR_PEND_RST = 32'h0000_0000;
    localparam logic [31:0] INTR_MASK_RST = 32'h0000_0000;

endpackage

// File: rtl/common_configure_reg_interface.sv
// Link between the configure centre (master) and one configuration register slice (slave).
interface common_configure_reg_interface #(
    parameter int ASIZE = 8,
    parameter int DSIZE = 32
);
    logic [DSIZE-1:0] wdata;
    logic [DSIZE-1:0] rdata;
    logic [DSIZE-1:0] default_value;
    logic [ASIZE-1:0] addr;
    logic             rst;
    logic             interrupt_trigger;
    logic             interrupt_enable;

    modport master (
        output wdata,
        input  rdata, addr, default_value, rst, interrupt_trigger, interrupt_enable
    );

    modport slave (
        input  wdata,
        output rdata, addr, default_value, rst, interrupt_trigger, interrupt_enable
    );
endinterface

// File: rtl/cfg_center_slot.sv
// One register slot: holds the value driven to a slice, matches its address and
// tracks the slice's interrupt-pending bit.
module cfg_center_slot #(
    parameter int ASIZE = 8,
    parameter int DSIZE = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             init_i,
    input  logic             slice_rst_i,
    input  logic [DSIZE-1:0] default_value_i,
    input  logic [ASIZE-1:0] slice_addr_i,
    input  logic             wr_en_i,
    input  logic [ASIZE-1:0] wr_addr_i,
    input  logic [DSIZE-1:0] wr_data_i,
    input  logic [ASIZE-1:0] rd_addr_i,
    input  logic             trigger_i,
    input  logic             intr_enable_i,
    input  logic             pend_clr_i,
    output logic [DSIZE-1:0] wreg_o,
    output logic             rd_match_o,
    output logic             pending_o
);
    logic [DSIZE-1:0] wreg_q;
    logic [DSIZE-1:0] wreg_d;
    logic             trig_q;
    logic             pending_q;
    logic             pending_d;
    logic             wr_hit;
    logic             pend_set;

    assign wr_hit     = wr_en_i && (wr_addr_i == slice_addr_i);
    assign rd_match_o = (rd_addr_i == slice_addr_i);

    always_comb begin
        // NOTE: hold is the default so every path assigns wreg_d and no latch is inferred.
        wreg_d = wreg_q;
        if (init_i || slice_rst_i) begin
            wreg_d = default_value_i;
        end else if (wr_hit) begin
            wreg_d = wr_data_i;
        end
    end

    // A new trigger edge beats a same-cycle W1C clear.
    assign pend_set  = trigger_i && !trig_q && intr_enable_i;
    assign pending_d = pend_set || (pending_q && !pend_clr_i);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the value register is reset so the slice never sees X before INIT loads defaults.
            wreg_q    <= '0;
            trig_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            wreg_q    <= wreg_d;
            trig_q    <= trigger_i;
            pending_q <= pending_d;
        end
    end

    assign wreg_o    = wreg_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/axi_lite_cfg_reg_center.sv
// AXI4-Lite slave that writes and reads a bank of configuration register slices
// and aggregates their interrupts into one level IRQ.
module axi_lite_cfg_reg_center
    import cfg_center_pkg::*;
#(
    parameter int               NUM            = 16,
    parameter int               ASIZE          = 8,
    parameter int               DSIZE          = 32,
    parameter logic [ASIZE-1:0] INTR_PEND_ADDR = 8'hFE,
    parameter logic [ASIZE-1:0] INTR_MASK_ADDR = 8'hFF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [ASIZE+1:0] awaddr,
    input  logic             awvalid,
    output logic             awready,
    input  logic [DSIZE-1:0] wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    input  logic [ASIZE+1:0] araddr,
    input  logic             arvalid,
    output logic             arready,
    output logic [DSIZE-1:0] rdata,
    output logic [1:0]       rresp,
    output logic             rvalid,
    input  logic             rready,
    common_configure_reg_interface.master cfg_inf [NUM],
    output logic             irq
);
    wr_state_t        wr_state_q;
    rd_state_t        rd_state_q;
    logic             init_q;
    logic             awready_q;
    logic             wready_q;
    logic             bvalid_q;
    logic             arready_q;
    logic             rvalid_q;
    logic [ASIZE-1:0] waddr_q;
    logic [DSIZE-1:0] wdata_q;
    logic [DSIZE-1:0] rdata_q;
    logic [NUM-1:0]   mask_q;
    logic             irq_q;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic             wr_is_pend;
    logic             wr_is_mask;
    logic             slot_wr_en;
    logic [NUM-1:0]   pend_clr;
    logic [NUM-1:0]   pending;
    logic [NUM-1:0]   rd_match;
    logic [ASIZE-1:0] rd_addr;
    logic [DSIZE-1:0] rd_mux;
    logic [DSIZE-1:0] slice_rdata [NUM];
    logic [DSIZE-1:0] wreg        [NUM];
    logic             unused_addr_lsb;

    // Byte-lane bits carry no information: every access is a full word.
    assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

    assign aw_hs      = awvalid && awready_q;
    assign w_hs       = wvalid && wready_q;
    assign ar_hs      = arvalid && arready_q;
    assign rd_addr    = araddr[ASIZE+1:2];

    assign commit     = (wr_state_q == W_COMMIT);
    assign wr_is_pend = (waddr_q == INTR_PEND_ADDR);
    assign wr_is_mask = (waddr_q == INTR_MASK_ADDR);
    assign slot_wr_en = commit && !wr_is_pend && !wr_is_mask;
    assign pend_clr   = (commit && wr_is_pend) ? wdata_q[NUM-1:0] : '0;

    for (genvar g = 0; g < NUM; g++) begin : g_slot
        cfg_center_slot #(
            .ASIZE (ASIZE),
            .DSIZE (DSIZE)
        ) u_slot (
            .clock           (clock),
            .rst_n           (rst_n),
            .init_i          (init_q),
            .slice_rst_i     (cfg_inf[g].rst),
            .default_value_i (cfg_inf[g].default_value),
            .slice_addr_i    (cfg_inf[g].addr),
            .wr_en_i         (slot_wr_en),
            .wr_addr_i       (waddr_q),
            .wr_data_i       (wdata_q),
            .rd_addr_i       (rd_addr),
            .trigger_i       (cfg_inf[g].interrupt_trigger),
            .intr_enable_i   (cfg_inf[g].interrupt_enable),
            .pend_clr_i      (pend_clr[g]),
            .wreg_o          (wreg[g]),
            .rd_match_o      (rd_match[g]),
            .pending_o       (pending[g])
        );

        assign cfg_inf[g].wdata = wreg[g];
        assign slice_rdata[g]   = cfg_inf[g].rdata;
    end

    // Reserved registers shadow any slice at the same address; among slices the lowest index wins.
    always_comb begin
        rd_mux = '0;
        if (rd_addr == INTR_PEND_ADDR) begin
            rd_mux = DSIZE'(pending);
        end else if (rd_addr == INTR_MASK_ADDR) begin
            rd_mux = DSIZE'(mask_q);
        end else begin
            for (int i = NUM - 1; i >= 0; i--) begin
                if (rd_match[i]) begin
                    rd_mux = slice_rdata[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else if (init_q) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
        end else begin
            case (wr_state_q)
                W_IDLE, W_WAIT: begin
                    if (aw_hs) begin
                        waddr_q   <= awaddr[ASIZE+1:2];
                        awready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wdata_q  <= wdata;
                        wready_q <= 1'b0;
                    end
                    // A channel counts as done if it handshakes now or was latched earlier.
                    if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
                        wr_state_q <= W_COMMIT;
                    end else if (aw_hs || w_hs) begin
                        wr_state_q <= W_WAIT;
                    end
                end
                W_COMMIT: begin
                    wr_state_q <= W_RESP;
                    bvalid_q   <= 1'b1;
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else if (init_q) begin
            arready_q  <= 1'b1;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state_q <= R_RESP;
                        rdata_q    <= rd_mux;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rd_state_q <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= INTR_MASK_RST[NUM-1:0];
            irq_q  <= 1'b0;
        end else begin
            if (commit && wr_is_mask) begin
                mask_q <= wdata_q[NUM-1:0];
            end
            irq_q <= |(pending & mask_q);
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = RESP_OKAY;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = RESP_OKAY;
    assign irq     = irq_q;

endmodule

// File: tb/tb_axi_lite_cfg_reg_center.sv
// Scoreboard bench: directed scenarios plus randomized AXI traffic against a register-map model.
module tb_axi_lite_cfg_reg_center;
    import cfg_center_pkg::*;

    localparam int NUM   = 16;
    localparam int ASIZE = 8;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [9:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        irq;
    logic [NUM-1:0] trig = '0;
    logic [NUM-1:0] ien  = '0;

    always #5 clock = ~clock;

    common_configure_reg_interface #(.ASIZE(ASIZE), .DSIZE(32)) cfg_if [NUM] ();
    logic [31:0] slice_wdata [NUM];

    // Slice map: slice 4 collides with the pending register, slice 15 duplicates slice 14.
    function automatic logic [7:0] slice_addr(int i);
        if (i == 4)  return 8'hFE;
        if (i == 15) return 8'h0E;
        return 8'(i);
    endfunction

    function automatic logic [31:0] slice_default(int i);
        if (i == 3) return 32'h0000_1234;
        return 32'h1000_0000 + 32'(i << 4);
    endfunction

    function automatic logic [31:0] rd_xor(int i);
        return (i == 15) ? 32'hFFFF_0000 : 32'h0;
    endfunction

    for (genvar g = 0; g < NUM; g++) begin : g_slice
        assign cfg_if[g].addr              = slice_addr(g);
        assign cfg_if[g].default_value     = slice_default(g);
        assign cfg_if[g].rdata             = cfg_if[g].wdata ^ rd_xor(g);
        assign cfg_if[g].rst               = (g == 5) ? cfg_if[g].wdata[0] : 1'b0;
        assign cfg_if[g].interrupt_trigger = trig[g];
        assign cfg_if[g].interrupt_enable  = ien[g];
        assign slice_wdata[g]              = cfg_if[g].wdata;
    end

    axi_lite_cfg_reg_center #(
        .NUM   (NUM),
        .ASIZE (ASIZE),
        .DSIZE (32)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .cfg_inf (cfg_if),
        .irq     (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of the register map.
    logic [31:0]    m_reg [NUM];
    logic [NUM-1:0] m_pend;
    logic [NUM-1:0] m_mask;
    logic [31:0]    exp_r_q [$];
    logic [1:0]     exp_b_q [$];

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) m_reg[i] = slice_default(i);
        m_pend = '0;
        m_mask = '0;
    endtask

    task automatic model_write(logic [7:0] a, logic [31:0] d);
        if (a == 8'hFE) begin
            m_pend = m_pend & ~d[NUM-1:0];
        end else if (a == 8'hFF) begin
            m_mask = d[NUM-1:0];
        end else begin
            for (int i = 0; i < NUM; i++)
                if (slice_addr(i) == a) m_reg[i] = (i == 5 && d[0]) ? slice_default(5) : d;
        end
    endtask

    function automatic logic [31:0] model_read(logic [7:0] a);
        if (a == 8'hFE) return 32'(m_pend);
        if (a == 8'hFF) return 32'(m_mask);
        for (int i = 0; i < NUM; i++)
            if (slice_addr(i) == a) return m_reg[i] ^ rd_xor(i);
        return 32'h0;
    endfunction

    // Monitor: pops the scoreboard whenever a response handshake is about to complete.
    always @(negedge clock) begin
        if (rst_n && bvalid && bready) begin
            if (exp_b_q.size() == 0) check("b_spurious", 32'(exp_b_q.size()), 32'd1);
            else check("bresp", 32'(bresp), 32'(exp_b_q.pop_front()));
        end
        if (rst_n && rvalid && rready) begin
            if (exp_r_q.size() == 0) check("r_spurious", 32'(exp_r_q.size()), 32'd1);
            else begin
                check("rdata", rdata, exp_r_q.pop_front());
                check("rresp", 32'(rresp), 32'(RESP_OKAY));
            end
        end
    end

    task automatic drive_aw(logic [9:0] a, int dly);
        int hs = 0;
        repeat (dly + 1) @(posedge clock);
        #1 awaddr = a; awvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (awready) begin hs = 1; break; end
        end
        @(posedge clock); #1 awvalid = 1'b0;
        check("aw_handshake", 32'(hs), 32'd1);
    endtask

    task automatic drive_w(logic [31:0] d, int dly);
        int hs = 0;
        repeat (dly + 1) @(posedge clock);
        #1 wdata = d; wvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (wready) begin hs = 1; break; end
        end
        @(posedge clock); #1 wvalid = 1'b0;
        check("w_handshake", 32'(hs), 32'd1);
    endtask

    task automatic wait_b(int dly);
        int hs = 0;
        repeat (dly) @(posedge clock);
        #1 bready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (bvalid) begin hs = 1; break; end
        end
        @(posedge clock); #1 bready = 1'b0;
        check("b_handshake", 32'(hs), 32'd1);
    endtask

    task automatic axi_write(logic [9:0] a, logic [31:0] d, int aw_dly, int w_dly, int b_dly);
        exp_b_q.push_back(RESP_OKAY);
        model_write(a[9:2], d);
        fork
            drive_aw(a, aw_dly);
            drive_w(d, w_dly);
        join
        wait_b(b_dly);
        @(posedge clock); #1;
    endtask

    // While rready is held low the response must stay put and no new address is accepted.
    task automatic axi_read(logic [9:0] a, int ar_dly, int r_dly);
        int hs = 0;
        logic [31:0] exp;
        exp = model_read(a[9:2]);
        exp_r_q.push_back(exp);
        repeat (ar_dly + 1) @(posedge clock);
        #1 araddr = a; arvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (arready) begin hs = 1; break; end
        end
        @(posedge clock); #1 arvalid = 1'b0;
        check("ar_handshake", 32'(hs), 32'd1);
        for (int k = 0; k < r_dly; k++) begin
            @(negedge clock);
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, exp);
            check("arready_busy", 32'(arready), 32'd0);
            @(posedge clock); #1;
        end
        rready = 1'b1;
        hs = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (rvalid) begin hs = 1; break; end
        end
        @(posedge clock); #1 rready = 1'b0;
        check("r_handshake", 32'(hs), 32'd1);
    endtask

    task automatic pulse_trig(int i);
        @(posedge clock); #1 trig[i] = 1'b1;
        if (ien[i]) m_pend[i] = 1'b1;
        @(posedge clock); #1 trig[i] = 1'b0;
    endtask

    task automatic check_irq(string name);
        repeat (2) @(posedge clock);
        #1;
        check(name, 32'(irq), 32'(|(m_pend & m_mask)));
    endtask

    task automatic check_slices();
        for (int i = 0; i < NUM; i++)
            check($sformatf("slice_wdata[%0d]", i), slice_wdata[i], m_reg[i]);
    endtask

    function automatic logic [7:0] pick_addr();
        int r = $urandom_range(0, 19);
        if (r < 16) return 8'(r);
        case (r)
            16:      return 8'h10;
            17:      return 8'h55;
            18:      return 8'hFE;
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        int cnt;
        model_reset();
        ien = 16'h0004;

        // Reset and INIT
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_wreg3", slice_wdata[3], 32'd0);
        @(posedge clock); #1 rst_n = 1'b1;
        @(negedge clock);
        check("init_awready", 32'(awready), 32'd0);
        check("init_arready", 32'(arready), 32'd0);
        @(posedge clock); @(negedge clock);
        check("init_default3", slice_wdata[3], 32'h0000_1234);
        check("run_awready", 32'(awready), 32'd1);
        check_slices();

        // Split write: AW first, W a few cycles later
        exp_b_q.push_back(RESP_OKAY);
        model_write(8'h03, 32'hA5A5_0001);
        drive_aw(10'h00C, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("awready_wait", 32'(awready), 32'd0);
        end
        drive_w(32'hA5A5_0001, 0);
        wait_b(0);
        @(posedge clock); #1;
        check("split_slot3", slice_wdata[3], 32'hA5A5_0001);
        axi_read(10'h00C, 0, 0);

        // Self-clearing pulse register
        cnt = 0;
        fork
            axi_write(10'h014, 32'h1, 0, 0, 0);
            begin
                repeat (12) begin
                    @(negedge clock);
                    if (slice_wdata[5][0]) cnt++;
                end
            end
        join
        check("pulse_width", 32'(cnt), 32'd1);
        check("pulse_slot5", slice_wdata[5], slice_default(5));

        // Duplicate addresses and reserved-address override
        axi_write(10'h038, 32'hCAFE_0010, 1, 0, 2);
        check_slices();
        axi_read(10'h038, 0, 1);

        // Interrupt set, read-back, W1C clear with 1-cycle irq lag
        axi_write(10'h3FC, 32'h4, 0, 0, 0);
        pulse_trig(2);
        check_irq("irq_set");
        check("irq_high", 32'(irq), 32'd1);
        axi_read(10'h3F8, 0, 0);
        fork
            axi_write(10'h3F8, 32'h4, 0, 0, 0);
            begin
                int seen = 0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clock);
                    if (bvalid) begin seen = 1; break; end
                end
                check("irq_lag", 32'(irq), 32'd1);
                @(negedge clock);
                check("irq_fall", 32'(irq), 32'd0);
                check("irq_bvalid_seen", 32'(seen), 32'd1);
            end
        join
        check("slot4_untouched", slice_wdata[4], m_reg[4]);

        // Trigger edge in the same cycle as the W1C clear: the set wins
        exp_b_q.push_back(RESP_OKAY);
        model_write(8'hFE, 32'h4);
        m_pend[2] = 1'b1;
        @(posedge clock); #1 awaddr = 10'h3F8; awvalid = 1'b1; wdata = 32'h4; wvalid = 1'b1;
        @(negedge clock);
        check("both_ready", 32'(awready && wready), 32'd1);
        @(posedge clock); #1 awvalid = 1'b0; wvalid = 1'b0; trig[2] = 1'b1;
        @(posedge clock); #1 trig[2] = 1'b0;
        wait_b(0);
        axi_read(10'h3F8, 0, 0);
        check_irq("irq_set_wins");

        // Unmatched read with 5 cycles of back-pressure
        axi_read(10'h040, 0, 5);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int op = $urandom_range(0, 9);
            if (op < 5) begin
                axi_write({pick_addr(), 2'b00}, $urandom(), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
                check_slices();
                check_irq("irq_rand_wr");
            end else if (op < 9) begin
                axi_read({pick_addr(), 2'b00}, $urandom_range(0, 2), $urandom_range(0, 3));
            end else begin
                int i = $urandom_range(0, NUM - 1);
                ien[i] = 1'($urandom_range(0, 1));
                pulse_trig(i);
                check_irq("irq_rand_trig");
            end
        end

        // Reset asserted during W_COMMIT: write lost, no B response
        @(posedge clock); #1 awaddr = 10'h01C; awvalid = 1'b1; wdata = 32'hDEAD_BEE0; wvalid = 1'b1;
        @(posedge clock); #1 awvalid = 1'b0; wvalid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("bvalid_in_reset", 32'(bvalid), 32'd0);
        end
        @(posedge clock); #1 rst_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("bvalid_after_reset", 32'(bvalid), 32'd0);
        check("irq_after_reset", 32'(irq), 32'd0);
        check_slices();
        axi_read(10'h01C, 0, 0);

        repeat (3) @(posedge clock);
        check("b_leftover", 32'(exp_b_q.size()), 32'd0);
        check("r_leftover", 32'(exp_r_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d checks done", checks);
        $fatal(1, "watchdog");
    end

endmodule
